adc_config_sequencer: RTL and testbench

Sequences and arbitrates configuration traffic to the ADC serial-port controller. Latches requests for full-register init, DES enable and DES disable from any source (UART command decoder, power-up, calibration), issues exactly one single-cycle start pulse at a time, and tracks completion through the controller's active-low select line. Performs an automatic init after power-on, tracks the current DES mode, and flags a stuck serial transfer. Sits between the command logic and the ADC serial controller; it is the only driver of that controller's `init`, `des_enable` and `des_disable` inputs.

---
 rtl/adc_config_sequencer.sv | 163 ++++++++++++++++
 tb/tb_adc_config_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_config_sequencer.sv
// Arbitrates init / DES-enable / DES-disable requests into single start pulses for the ADC serial controller.
// Optional: define ADC_SEQ_RESTORE_DES_EN to re-apply DES automatically after a successful init.
module adc_config_sequencer #(
    parameter int POR_DELAY     = 1024,
    parameter int START_TIMEOUT = 8,
    parameter int XFER_TIMEOUT  = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic req_init,
    input  logic req_des_en,
    input  logic req_des_dis,
    input  logic adc_select,
    output logic init,
    output logic des_enable,
    output logic des_disable,
    output logic busy,
    output logic done,
    output logic des_active,
    output logic err_timeout
);

    localparam int TMAX = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(POR_DELAY + 1);

    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT - 1);
    localparam logic [PW-1:0] POR_LAST   = PW'(POR_DELAY - 1);

    typedef enum logic [2:0] {
        S_POR_WAIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        CMD_INIT,
        CMD_EN,
        CMD_DIS
    } cmd_t;

    state_t          state;
    cmd_t            cmd;
    logic            p_init, p_en, p_dis;
    logic [PW-1:0]   por_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            restore_en;

`ifdef ADC_SEQ_RESTORE_DES_EN
    assign restore_en = (state == S_DONE) && (cmd == CMD_INIT) && des_active;
`else
    assign restore_en = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_POR_WAIT;
            cmd         <= CMD_INIT;
            p_init      <= 1'b1;
            p_en        <= 1'b0;
            p_dis       <= 1'b0;
            por_cnt     <= '0;
            tmo_cnt     <= '0;
            init        <= 1'b0;
            des_enable  <= 1'b0;
            des_disable <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            des_active  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle; the state case below raises at most one of them.
            init        <= 1'b0;
            des_enable  <= 1'b0;
            des_disable <= 1'b0;
            done        <= 1'b0;

            case (state)
                S_POR_WAIT: begin
                    if (por_cnt == POR_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        por_cnt <= por_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (p_init) begin
                        cmd    <= CMD_INIT;
                        p_init <= 1'b0;
                        state  <= S_ISSUE;
                        busy   <= 1'b1;
                    end else if (p_dis) begin
                        cmd   <= CMD_DIS;
                        p_dis <= 1'b0;
                        state <= S_ISSUE;
                        busy  <= 1'b1;
                    end else if (p_en) begin
                        cmd   <= CMD_EN;
                        p_en  <= 1'b0;
                        state <= S_ISSUE;
                        busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    init        <= (cmd == CMD_INIT);
                    des_enable  <= (cmd == CMD_EN);
                    des_disable <= (cmd == CMD_DIS);
                    tmo_cnt     <= '0;
                    state       <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (!adc_select) begin
                        tmo_cnt <= '0;
                        state   <= S_WAIT_DONE;
                    end else if (tmo_cnt == START_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (adc_select) begin
                        state <= S_DONE;
                    end else if (tmo_cnt == XFER_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done       <= 1'b1;
                    des_active <= (cmd == CMD_EN);
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= S_POR_WAIT;
                    busy  <= 1'b1;
                end
            endcase

            // Requests are applied after the grant so a request in the grant cycle re-arms its flag.
            if (req_init) p_init <= 1'b1;
            if (req_des_dis) begin
                p_dis <= 1'b1;
                p_en  <= 1'b0;
            end else if (req_des_en || restore_en) begin
                p_en  <= 1'b1;
                p_dis <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_config_sequencer.sv
// Scoreboard bench for adc_config_sequencer: stimulus pushes expected events, a monitor pops on every DUT output event.
module tb_adc_config_sequencer;

    localparam int POR_DELAY     = 16;
    localparam int START_TIMEOUT = 8;
    localparam int XFER_TIMEOUT  = 64;

    typedef enum logic [2:0] {EV_INIT, EV_EN, EV_DIS, EV_DONE, EV_TMO} ev_t;
    typedef struct {
        ev_t  ev;
        logic des;
    } exp_t;

    typedef enum logic [1:0] {M_NORMAL, M_NOSTART, M_STUCK} mode_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_init = 1'b0, req_des_en = 1'b0, req_des_dis = 1'b0;
    logic adc_select;
    logic init, des_enable, des_disable, busy, done, des_active, err_timeout;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    mode_t ctl_mode = M_NORMAL;
    int    ctl_len  = 20;

    always #5 clk = ~clk;

    adc_config_sequencer #(
        .POR_DELAY    (POR_DELAY),
        .START_TIMEOUT(START_TIMEOUT),
        .XFER_TIMEOUT (XFER_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_init   (req_init),
        .req_des_en (req_des_en),
        .req_des_dis(req_des_dis),
        .adc_select (adc_select),
        .init       (init),
        .des_enable (des_enable),
        .des_disable(des_disable),
        .busy       (busy),
        .done       (done),
        .des_active (des_active),
        .err_timeout(err_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic push(input ev_t e, input logic d);
        exp_t item;
        item.ev  = e;
        item.des = d;
        sb.push_back(item);
    endtask

    task automatic got_event(input ev_t e);
        exp_t item;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got %0d expected none at %0t", e, $time);
        end else begin
            item = sb.pop_front();
            check("event_order", 32'(e), 32'(item.ev));
            if (e == EV_DONE) check("des_at_done", 32'(des_active), 32'(item.des));
        end
    endtask

    // Controller model: select falls one cycle after a pulse and stays low for the transfer length.
    initial begin
        int len;
        adc_select = 1'b1;
        forever begin
            @(negedge clk);
            if ((init || des_enable || des_disable) && ctl_mode != M_NOSTART) begin
                len = (ctl_mode == M_STUCK) ? XFER_TIMEOUT + 10 : ctl_len;
                @(negedge clk);
                adc_select = 1'b0;
                repeat (len) @(negedge clk);
                adc_select = 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        logic prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (32'(init) + 32'(des_enable) + 32'(des_disable) > 1)
                check("onehot_pulse", 32'(init) + 32'(des_enable) + 32'(des_disable), 1);
            if (init)        got_event(EV_INIT);
            if (des_enable)  got_event(EV_EN);
            if (des_disable) got_event(EV_DIS);
            if (done)        got_event(EV_DONE);
            if (err_timeout && !prev_err) got_event(EV_TMO);
            prev_err = err_timeout;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_req(input logic i, input logic e, input logic d);
        @(negedge clk);
        req_init = i; req_des_en = e; req_des_dis = d;
        @(negedge clk);
        req_init = 1'b0; req_des_en = 1'b0; req_des_dis = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int run = 0;
        int cyc = 0;
        while (run < 3 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            run = busy ? 0 : run + 1;
        end
        if (run < 3) fail_bound(name);
    endtask

    task automatic wait_sel(input logic level, input int budget, input string name);
        int cyc = 0;
        while (cyc < budget) begin
            @(posedge clk);
            cyc++;
            if (adc_select == level) break;
        end
        if (adc_select != level) fail_bound(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_init"},        32'(init), 0);
        check({tag, "_des_enable"},  32'(des_enable), 0);
        check({tag, "_des_disable"}, 32'(des_disable), 0);
        check({tag, "_done"},        32'(done), 0);
        check({tag, "_err"},         32'(err_timeout), 0);
        check({tag, "_des_active"},  32'(des_active), 0);
        check({tag, "_busy"},        32'(busy), 1);
    endtask

    initial begin
        int cnt;

        // Power-on: automatic init 18 cycles after reset release
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        push(EV_INIT, 1'b0);
        push(EV_DONE, 1'b0);
        ctl_len = 20;
        rst = 1'b0;
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (init) break;
        end
        check("por_init_cycle", cnt, 18);
        wait_idle(100, "por_idle");
        check("por_busy", 32'(busy), 0);
        check("por_des_active", 32'(des_active), 0);
        check("por_err", 32'(err_timeout), 0);

        // Arbitration: en+dis together -> only disable, pulse two cycles after the sampling edge
        ctl_len = 5;
        push(EV_DIS, 1'b0);
        push(EV_DONE, 1'b0);
        @(negedge clk);
        req_des_en = 1'b1; req_des_dis = 1'b1;
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            cnt++;
            req_des_en = 1'b0; req_des_dis = 1'b0;
            if (des_disable) break;
        end
        check("req_latency", cnt, 3);
        wait_idle(100, "arb1_idle");

        // init + des_en together -> init first, then des_enable
        push(EV_INIT, 1'b0);
        push(EV_DONE, 1'b0);
        push(EV_EN, 1'b0);
        push(EV_DONE, 1'b1);
        pulse_req(1'b1, 1'b1, 1'b0);
        wait_idle(200, "arb2_idle");
        check("arb2_des_active", 32'(des_active), 1);

        // Queued: des_en during an init transfer, repeated request gives no extra pulse
        ctl_len = 20;
        push(EV_INIT, 1'b0);
        push(EV_DONE, 1'b0);
        push(EV_EN, 1'b0);
        push(EV_DONE, 1'b1);
        pulse_req(1'b1, 1'b0, 1'b0);
        wait_sel(1'b0, 20, "queue_sel_low");
        pulse_req(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        pulse_req(1'b0, 1'b1, 1'b0);
        wait_idle(200, "queue_idle");
        check("queue_des_active", 32'(des_active), 1);

        // Start timeout: select never falls
        ctl_mode = M_NOSTART;
        push(EV_DIS, 1'b0);
        push(EV_TMO, 1'b0);
        pulse_req(1'b0, 1'b0, 1'b1);
        cnt = 0;
        while (cnt < 10 && !des_disable) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        while (cnt < 50 && !err_timeout) begin
            @(negedge clk);
            cnt++;
        end
        check("start_timeout_cycles", cnt, START_TIMEOUT);
        wait_idle(50, "stmo_idle");
        check("stmo_des_active", 32'(des_active), 1);

        // Later request still serviced; err stays sticky
        ctl_mode = M_NORMAL;
        ctl_len  = 4;
        push(EV_DIS, 1'b0);
        push(EV_DONE, 1'b0);
        pulse_req(1'b0, 1'b0, 1'b1);
        wait_idle(100, "after_tmo_idle");
        check("after_tmo_des_active", 32'(des_active), 0);
        check("err_sticky", 32'(err_timeout), 1);

        // Transfer timeout: select stuck low, des_active unchanged, no done
        ctl_mode = M_STUCK;
        push(EV_EN, 1'b0);
        pulse_req(1'b0, 1'b1, 1'b0);
        wait_idle(XFER_TIMEOUT + 30, "xtmo_idle");
        check("xtmo_des_active", 32'(des_active), 0);
        check("xtmo_err", 32'(err_timeout), 1);
        wait_sel(1'b1, 100, "xtmo_sel_high");

        // Reset in WAIT_DONE
        push(EV_EN, 1'b0);
        pulse_req(1'b0, 1'b1, 1'b0);
        wait_sel(1'b0, 20, "rst_sel_low");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        ctl_mode = M_NORMAL;
        @(negedge clk);
        check_reset_outputs("midrst");
        check("midrst_sb_empty", sb.size(), 0);
        wait_sel(1'b1, 200, "midrst_sel_high");
        push(EV_INIT, 1'b0);
        push(EV_DONE, 1'b0);
        ctl_len = 6;
        @(negedge clk);
        rst = 1'b0;
        wait_idle(200, "midrst_por_idle");

        // Restore behaviour: des_en, then init
        push(EV_EN, 1'b0);
        push(EV_DONE, 1'b1);
        pulse_req(1'b0, 1'b1, 1'b0);
        wait_idle(100, "restore_en_idle");
        check("restore_pre_des_active", 32'(des_active), 1);
        push(EV_INIT, 1'b1);
        push(EV_DONE, 1'b0);
`ifdef ADC_SEQ_RESTORE_DES_EN
        push(EV_EN, 1'b0);
        push(EV_DONE, 1'b1);
`endif
        pulse_req(1'b1, 1'b0, 1'b0);
        wait_idle(200, "restore_idle");
`ifdef ADC_SEQ_RESTORE_DES_EN
        check("restore_final_des_active", 32'(des_active), 1);
`else
        check("restore_final_des_active", 32'(des_active), 0);
`endif

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
